// File: rtl/ibex_wb_forward_fpga.sv
// Writeback/forwarding stage that owns the FPGA register-file write port.
// Execute and late load results merge into one registered write stream; a colliding load waits in a one-entry buffer.
module ibex_wb_forward_fpga #(
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,
  output logic                 ex_stall_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o
);

  localparam logic [4:0] AddrMask  = RV32E ? 5'h0F : 5'h1F;
  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  function automatic logic [4:0] norm_addr(input logic [4:0] addr);
    return addr & AddrMask;
  endfunction

  // Newest uncommitted copy wins: stage register first, then the older buffered load.
  function automatic logic [DataWidth-1:0] fwd_sel(
    input logic [4:0]           raddr,
    input logic [DataWidth-1:0] rf_data,
    input logic                 s_valid,
    input logic [4:0]           s_addr,
    input logic [DataWidth-1:0] s_data,
    input logic                 b_valid,
    input logic [4:0]           b_addr,
    input logic [DataWidth-1:0] b_data
  );
    logic [DataWidth-1:0] result;
    if (raddr == 5'd0) begin
      result = rf_data;
    end else if (s_valid && (s_addr == raddr)) begin
      result = s_data;
    end else if (b_valid && (b_addr == raddr)) begin
      result = b_data;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

  logic                 s_valid_r, s_valid_s;
  logic [4:0]           s_addr_r, s_addr_s;
  logic [DataWidth-1:0] s_data_r, s_data_s;
  logic                 b_valid_r, b_valid_s;
  logic [4:0]           b_addr_r, b_addr_s;
  logic [DataWidth-1:0] b_data_r, b_data_s;
  logic [3:0]           c_r, c_s;
  logic                 stall_r, stall_s;
  logic                 ready_r, ready_s;

  logic [4:0] ex_addr_s;
  logic [4:0] lsu_addr_s;
  logic       ex_write_s;
  logic       lsu_write_s;

  assign ex_addr_s   = norm_addr(ex_waddr_i);
  assign lsu_addr_s  = norm_addr(lsu_waddr_i);
  assign ex_write_s  = ex_we_i & ~stall_r & (ex_addr_s != 5'd0);
  // Loads to x0 are still handshaken, they just never produce a write.
  assign lsu_write_s = lsu_valid_i & ready_r & (lsu_addr_s != 5'd0);

  // Stage register selection: execute, then buffered load, then fresh load.
  always_comb begin
    s_valid_s = 1'b0;
    s_addr_s  = 5'd0;
    s_data_s  = '0;
    if (ex_write_s) begin
      s_valid_s = 1'b1;
      s_addr_s  = ex_addr_s;
      s_data_s  = ex_wdata_i;
    end else if (b_valid_r) begin
      s_valid_s = 1'b1;
      s_addr_s  = b_addr_r;
      s_data_s  = b_data_r;
    end else if (lsu_write_s) begin
      s_valid_s = 1'b1;
      s_addr_s  = lsu_addr_s;
      s_data_s  = lsu_wdata_i;
    end else begin
      s_valid_s = 1'b0;
    end
  end

  // Load buffer, starvation counter and the flop-based handshake outputs.
  always_comb begin
    b_valid_s = b_valid_r;
    b_addr_s  = b_addr_r;
    b_data_s  = b_data_r;
    c_s       = c_r;
    if (b_valid_r) begin
      if (ex_write_s) begin
        if (ex_addr_s == b_addr_r) begin
          // The buffered load is older than this execute result: drop it.
          b_valid_s = 1'b0;
          c_s       = 4'd0;
        end else if (c_r >= StarveMax) begin
          c_s = StarveMax;
        end else begin
          c_s = c_r + 4'd1;
        end
      end else begin
        b_valid_s = 1'b0;
        c_s       = 4'd0;
      end
    end else begin
      c_s = 4'd0;
      if (lsu_write_s && ex_write_s && (lsu_addr_s != ex_addr_s)) begin
        b_valid_s = 1'b1;
        b_addr_s  = lsu_addr_s;
        b_data_s  = lsu_wdata_i;
      end else begin
        b_valid_s = 1'b0;
      end
    end
    stall_s = b_valid_s & (c_s == StarveMax);
    ready_s = ~b_valid_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_valid_r <= 1'b0;
      s_addr_r  <= 5'd0;
      s_data_r  <= '0;
      b_valid_r <= 1'b0;
      b_addr_r  <= 5'd0;
      b_data_r  <= '0;
      c_r       <= 4'd0;
      stall_r   <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      s_valid_r <= s_valid_s;
      s_addr_r  <= s_addr_s;
      s_data_r  <= s_data_s;
      b_valid_r <= b_valid_s;
      b_addr_r  <= b_addr_s;
      b_data_r  <= b_data_s;
      c_r       <= c_s;
      stall_r   <= stall_s;
      ready_r   <= ready_s;
    end
  end

  assign rf_we_o     = s_valid_r;
  assign rf_waddr_o  = s_addr_r;
  assign rf_wdata_o  = s_data_r;
  assign lsu_ready_o = ready_r;
  assign ex_stall_o  = stall_r;

  assign rdata_a_o = fwd_sel(norm_addr(raddr_a_i), rf_rdata_a_i, s_valid_r, s_addr_r, s_data_r,
                             b_valid_r, b_addr_r, b_data_r);
  assign rdata_b_o = fwd_sel(norm_addr(raddr_b_i), rf_rdata_b_i, s_valid_r, s_addr_r, s_data_r,
                             b_valid_r, b_addr_r, b_data_r);

endmodule

// File: tb/tb_ibex_wb_forward_fpga.sv
// Bench for ibex_wb_forward_fpga: register-file model plus a write scoreboard.
// A second instance with RV32E=1 covers the address aliasing.
module tb_ibex_wb_forward_fpga;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        lsu_valid;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic        lsu_ready, ex_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rdata_a, rdata_b;
  logic        e_lsu_ready, e_ex_stall, e_rf_we;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata, e_rdata_a, e_rdata_b;
  logic [31:0] e_rf_rdata;

  logic [31:0] regs [32] = '{default: 32'h0};
  wr_t         exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign rf_rdata_a = regs[raddr_a];
  assign rf_rdata_b = regs[raddr_b];
  assign e_rf_rdata = 32'hDEAD_0000;

  ibex_wb_forward_fpga u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .lsu_ready_o(lsu_ready), .ex_stall_o(ex_stall),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
    .rdata_a_o(rdata_a), .rdata_b_o(rdata_b)
  );

  ibex_wb_forward_fpga #(.RV32E(1'b1)) u_dut_e (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .lsu_ready_o(e_lsu_ready), .ex_stall_o(e_ex_stall),
    .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rf_rdata_a_i(e_rf_rdata), .rf_rdata_b_i(e_rf_rdata),
    .rdata_a_o(e_rdata_a), .rdata_b_o(e_rdata_b)
  );

  // Register file model: commits at the end of the cycle rf_we is high.
  always @(posedge clk) begin
    if (rf_we === 1'b1) regs[rf_waddr] <= rf_wdata;
  end

  // Scoreboard: every write on the rf port must be the next expected one.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got x%0d=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== {e.addr, e.data}) begin
          n_fail++;
          $display("FAIL sb_write: got x%0d=%h, required x%0d=%h", rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_we     = 1'b0;
    lsu_valid = 1'b0;
  endtask

  task automatic drive_ex(input logic [4:0] a, input logic [31:0] d);
    ex_we    = 1'b1;
    ex_waddr = a;
    ex_wdata = d;
  endtask

  task automatic drive_lsu(input logic [4:0] a, input logic [31:0] d);
    lsu_valid = 1'b1;
    lsu_waddr = a;
    lsu_wdata = d;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    drive_ex(5'd3, 32'h33);
    lsu_waddr = 5'd0;
    lsu_wdata = 32'h0;
    raddr_a   = 5'd3;
    raddr_b   = 5'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if ({rf_we, lsu_ready, ex_stall} !== 3'b010) begin
        n_fail++;
        $display("FAIL reset_flags: got we/ready/stall=%b, required 010", {rf_we, lsu_ready, ex_stall});
      end
    end
    n_tests++;
    if ({rf_waddr, rf_wdata, rdata_a} !== {5'd0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got waddr=%0d wdata=%h rdata_a=%h, required 0 0 0", rf_waddr, rf_wdata, rdata_a);
    end
    rst_n = 1'b1;
    push(5'd3, 32'h33);
    step();
    idle();
    n_tests++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33}) begin
      n_fail++;
      $display("FAIL reset_first_write: got we=%b x%0d=%h, required 1 x3=00000033", rf_we, rf_waddr, rf_wdata);
    end
    step();
    n_tests++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got we=%b, required 0", rf_we);
    end
  endtask

  task automatic test_collision();
    drive_ex(5'd5, 32'h11);
    drive_lsu(5'd6, 32'h22);
    push(5'd5, 32'h11);
    push(5'd6, 32'h22);
    n_tests++;
    if (lsu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_ready_before: got %b, required 1", lsu_ready);
    end
    step();
    idle();
    raddr_a = 5'd5;
    raddr_b = 5'd6;
    #1;
    n_tests++;
    if ({rf_we, rf_waddr, rf_wdata, lsu_ready} !== {1'b1, 5'd5, 32'h11, 1'b0}) begin
      n_fail++;
      $display("FAIL coll_ex_first: got we=%b x%0d=%h ready=%b, required 1 x5=00000011 0", rf_we, rf_waddr, rf_wdata, lsu_ready);
    end
    n_tests++;
    if ({rdata_a, rdata_b} !== {32'h11, 32'h22}) begin
      n_fail++;
      $display("FAIL coll_fwd: got a=%h b=%h, required 00000011 00000022", rdata_a, rdata_b);
    end
    step();
    n_tests++;
    if ({rf_we, rf_waddr, rf_wdata, lsu_ready} !== {1'b1, 5'd6, 32'h22, 1'b1}) begin
      n_fail++;
      $display("FAIL coll_load_drain: got we=%b x%0d=%h ready=%b, required 1 x6=00000022 1", rf_we, rf_waddr, rf_wdata, lsu_ready);
    end
    step();
    n_tests++;
    if ({rf_we, rdata_b} !== {1'b0, 32'h22}) begin
      n_fail++;
      $display("FAIL coll_committed: got we=%b b=%h, required 0 00000022", rf_we, rdata_b);
    end
  endtask

  task automatic test_forward();
    drive_ex(5'd7, 32'hA5A5);
    push(5'd7, 32'hA5A5);
    raddr_a = 5'd7;
    step();
    idle();
    n_tests++;
    if ({rdata_a, rf_rdata_a} !== {32'hA5A5, 32'h0}) begin
      n_fail++;
      $display("FAIL fwd_from_s: got rdata=%h raw=%h, required 0000a5a5 00000000", rdata_a, rf_rdata_a);
    end
    step();
    n_tests++;
    if (rdata_a !== 32'hA5A5) begin
      n_fail++;
      $display("FAIL fwd_from_rf: got %h, required 0000a5a5", rdata_a);
    end
  endtask

  task automatic test_stale_drop();
    drive_ex(5'd10, 32'h5);
    drive_lsu(5'd9, 32'h1);
    push(5'd10, 32'h5);
    step();
    idle();
    drive_ex(5'd9, 32'h2);
    push(5'd9, 32'h2);
    raddr_b = 5'd9;
    #1;
    n_tests++;
    if ({lsu_ready, rdata_b} !== {1'b0, 32'h1}) begin
      n_fail++;
      $display("FAIL stale_buffered: got ready=%b b=%h, required 0 00000001", lsu_ready, rdata_b);
    end
    step();
    idle();
    n_tests++;
    if ({rf_we, rf_waddr, rf_wdata, lsu_ready, rdata_b} !== {1'b1, 5'd9, 32'h2, 1'b1, 32'h2}) begin
      n_fail++;
      $display("FAIL stale_newer: got we=%b x%0d=%h ready=%b b=%h, required 1 x9=00000002 1 00000002", rf_we, rf_waddr, rf_wdata, lsu_ready, rdata_b);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if ({rf_we, rdata_b} !== {1'b0, 32'h2}) begin
        n_fail++;
        $display("FAIL stale_no_write: got we=%b b=%h, required 0 00000002", rf_we, rdata_b);
      end
    end
  endtask

  task automatic test_starvation();
    drive_ex(5'd11, 32'h100);
    drive_lsu(5'd12, 32'hBEEF);
    push(5'd11, 32'h100);
    step();
    lsu_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (ex_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL starve_early_stall: cycle %0d got %b, required 0", k, ex_stall);
      end
      drive_ex(5'd13, 32'h200 + 32'(k));
      push(5'd13, 32'h200 + 32'(k));
      step();
    end
    n_tests++;
    if ({ex_stall, lsu_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL starve_stall: got stall/ready=%b, required 10", {ex_stall, lsu_ready});
    end
    drive_ex(5'd13, 32'h300);
    push(5'd12, 32'hBEEF);
    step();
    idle();
    n_tests++;
    if ({rf_we, rf_waddr, rf_wdata, ex_stall, lsu_ready} !== {1'b1, 5'd12, 32'hBEEF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL starve_drain: got we=%b x%0d=%h stall=%b ready=%b, required 1 x12=0000beef 0 1", rf_we, rf_waddr, rf_wdata, ex_stall, lsu_ready);
    end
    step();
  endtask

  task automatic test_x0_and_load();
    drive_ex(5'd0, 32'h55);
    drive_lsu(5'd0, 32'h66);
    raddr_a = 5'd0;
    step();
    ex_we = 1'b0;
    n_tests++;
    if ({rf_we, lsu_ready, rdata_a} !== {1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL x0_dropped: got we=%b ready=%b a=%h, required 0 1 00000000", rf_we, lsu_ready, rdata_a);
    end
    drive_lsu(5'd14, 32'h77);
    push(5'd14, 32'h77);
    step();
    idle();
    n_tests++;
    if ({rf_we, rf_waddr, rf_wdata, lsu_ready} !== {1'b1, 5'd14, 32'h77, 1'b1}) begin
      n_fail++;
      $display("FAIL load_alone: got we=%b x%0d=%h ready=%b, required 1 x14=00000077 1", rf_we, rf_waddr, rf_wdata, lsu_ready);
    end
    step();
  endtask

  task automatic test_reset_midop();
    drive_ex(5'd20, 32'h2020);
    drive_lsu(5'd21, 32'h2121);
    push(5'd20, 32'h2020);
    step();
    idle();
    rst_n = 1'b0;
    step();
    exp_q.delete();
    rst_n   = 1'b1;
    raddr_b = 5'd21;
    #1;
    n_tests++;
    if ({rf_we, lsu_ready, ex_stall, rdata_b} !== {3'b010, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_midop: got we/ready/stall=%b b=%h, required 010 00000000", {rf_we, lsu_ready, ex_stall}, rdata_b);
    end
    step();
    n_tests++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop_lost: got we=%b, required 0", rf_we);
    end
  endtask

  task automatic test_rv32e();
    drive_ex(5'h13, 32'h77);
    push(5'h13, 32'h77);
    raddr_a = 5'h03;
    raddr_b = 5'h13;
    step();
    idle();
    n_tests++;
    if ({e_rf_we, e_rf_waddr, e_rf_wdata} !== {1'b1, 5'h03, 32'h77}) begin
      n_fail++;
      $display("FAIL rv32e_write: got we=%b x%0d=%h, required 1 x3=00000077", e_rf_we, e_rf_waddr, e_rf_wdata);
    end
    n_tests++;
    if ({e_rdata_a, e_rdata_b, rdata_a} !== {32'h77, 32'h77, 32'h33}) begin
      n_fail++;
      $display("FAIL rv32e_fwd: got e_a=%h e_b=%h a=%h, required 00000077 00000077 00000033", e_rdata_a, e_rdata_b, rdata_a);
    end
    drive_ex(5'h10, 32'h99);
    push(5'h10, 32'h99);
    raddr_a = 5'h10;
    step();
    idle();
    n_tests++;
    if ({e_rf_we, e_rdata_a, rf_we, rf_waddr} !== {1'b0, 32'hDEAD_0000, 1'b1, 5'h10}) begin
      n_fail++;
      $display("FAIL rv32e_x0: got e_we=%b e_a=%h we=%b waddr=%0d, required 0 dead0000 1 16", e_rf_we, e_rdata_a, rf_we, rf_waddr);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_collision();
    test_forward();
    test_stale_drop();
    test_starvation();
    test_x0_and_load();
    test_reset_midop();
    test_rv32e();
    idle();
    step();
    step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d pending writes, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_wb_forward_fpga.md
# ibex_wb_forward_fpga

Writeback/forwarding stage that sits directly upstream of the FPGA register file and owns its single write port. It merges two writeback sources, the execute result and a late load response, into one registered write stream, buffering one colliding load. It also forwards uncommitted write data onto both asynchronous read ports so that consumers never see stale operands.

## Interface
Parameters:
- RV32E, 0: when 1, only address bits [3:0] are significant; bit 4 is ignored for all compares and writes.
- DataWidth, 32: register data width.
- StarveLimit, 4: consecutive blocked cycles of a buffered load before execute is stalled (1..15).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- ex_we_i  in  1  execute writeback valid (ignored while ex_stall_o=1).
- ex_waddr_i  in  5  execute destination register.
- ex_wdata_i  in  DataWidth  execute result.
- lsu_valid_i  in  1  load writeback valid.
- lsu_waddr_i  in  5  load destination register.
- lsu_wdata_i  in  DataWidth  load data.
- lsu_ready_o  out  1  load accepted this cycle when valid&ready.
- ex_stall_o  out  1  execute must hold its writeback.
- rf_we_o  out  1  register file write enable.
- rf_waddr_o  out  5  register file write address.
- rf_wdata_o  out  DataWidth  register file write data.
- raddr_a_i / raddr_b_i  in  5  read addresses (shared with register file).
- rf_rdata_a_i / rf_rdata_b_i  in  DataWidth  raw register file read data.
- rdata_a_o / rdata_b_o  out  DataWidth  forwarded read data.

## Operation
- State: stage register S (valid, addr, data), driving rf_*_o directly; one-entry load buffer B (valid, addr, data); starvation counter C (4 bits).
- "ex write" = ex_we_i & !ex_stall_o & ex_waddr_i!=0. Load writes to x0 are accepted and dropped. Writes to x0 never enter S or B.
- lsu_ready_o = !B.valid (pure function of flops).
- Per-cycle selection into S, priority order:
  1. ex write -> S.
  2. else B.valid -> S, B cleared.
  3. else lsu_valid_i & lsu_ready_o (non-x0) -> S.
  4. else S.valid=0.
- lsu_valid_i & lsu_ready_o & ex write in the same cycle: ex -> S, load -> B.
- B holds data older than any ex write arriving while B is valid. If an ex write targets B.addr, B is invalidated that cycle without writing, because the stale value must not overwrite the newer one. C is cleared.
- Starvation: C increments each cycle that B.valid and an ex write takes S. C saturates at StarveLimit. ex_stall_o = B.valid & (C==StarveLimit). While stalled, rule 2 drains B and C clears. ex_stall_o drops the following cycle.
- Forwarding, per read port, in priority order: S.valid & addr match -> S.data; else B.valid & addr match -> B.data; else rf_rdata_*_i. Address 0 always passes rf data through (register file returns 0).
- Forward path is combinational from raddr_*_i and flops only; there is no path from ex_*/lsu_* inputs to rdata_*_o.

## Timing
- Reset (rst_ni=0 at clock edge): S.valid=0, B.valid=0, C=0. After reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, lsu_ready_o=1, ex_stall_o=0. rdata_*_o equals rf_rdata_*_i.
- Reset mid-operation discards B and S contents. The pending write is lost by design.
- Latency: an accepted write appears on rf_*_o the next cycle. The register file commits at the end of that cycle and is readable from the cycle after. Forwarding covers both uncommitted cycles, so reads see the write on the cycle immediately after acceptance.
- A load captured into B reaches rf_*_o at most StarveLimit+2 cycles after acceptance.
- lsu_ready_o stays low from the cycle after capture into B until the cycle after B drains.

## Test plan
- Reset: hold rst_ni=0 two cycles with ex_we_i=1 -> rf_we_o=0, lsu_ready_o=1, ex_stall_o=0. After release, first write appears one cycle later.
- Collision: ex x5=0x11 and load x6=0x22 same cycle -> cycle+1 rf writes x5=0x11. The load sits in B and lsu_ready_o=0. Next idle cycle rf writes x6=0x22.
- Forwarding: ex x7=0xA5A5 at cycle 0 -> raddr_a_i=7 returns 0xA5A5 at cycle 1 (from S) with rf_rdata_a_i=0. Buffered x6 returns B data on port b.
- Stale drop: load x9=0x1 buffered, then ex x9=0x2 -> only x9=0x2 is written, B invalid, and x9 never reads 0x1 afterwards.
- Starvation (StarveLimit=4): buffered load while ex writes every cycle -> ex_stall_o=1 after 4 blocked cycles. The next cycle rf writes the load, and ex_stall_o=0 one cycle later.
- x0 and RV32E: ex/load to x0 -> no rf_we_o. With RV32E=1, write addr 0x13 matches read addr 0x03 for forwarding.
